// File: rtl/bump_scan_ctrl.sv
// Sequential platform scanner: snapshots the platform table on a frame tick and
// walks it through one shared collision checker, latching the first landing found.
module bump_scan_ctrl #(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       fly,
    input  logic [NUM_BLOCKS*10-1:0]   plat_x,
    input  logic [NUM_BLOCKS*10-1:0]   plat_y,
    output logic [9:0]                 chk_block_x,
    output logic [9:0]                 chk_block_y,
    input  logic                       chk_bump,
    input  logic [9:0]                 chk_movement,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic [IDX_W-1:0]           hit_idx,
    output logic [9:0]                 movement,
    output logic                       overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    logic [1:0]                state_r;
    logic [1:0]                state_s;
    logic [IDX_W-1:0]          idx_r;
    logic [IDX_W-1:0]          idx_s;
    logic [NUM_BLOCKS*10-1:0]  snap_x_r;
    logic [NUM_BLOCKS*10-1:0]  snap_y_r;
    logic                      snap_load_s;
    logic                      hit_r;
    logic                      hit_s;
    logic [IDX_W-1:0]          hit_idx_r;
    logic [IDX_W-1:0]          hit_idx_s;
    logic [9:0]                movement_r;
    logic [9:0]                movement_s;
    logic                      busy_r;
    logic                      done_r;
    logic                      overrun_r;

    // Next-state and result-capture decisions for the scan sequencer
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        hit_s       = hit_r;
        hit_idx_s   = hit_idx_r;
        movement_s  = movement_r;
        snap_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick) begin
                    if (fly) begin
                        state_s    = ST_DONE;
                        hit_s      = 1'b0;
                        hit_idx_s  = '0;
                        movement_s = 10'd0;
                    end else begin
                        state_s     = ST_SCAN;
                        idx_s       = '0;
                        snap_load_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (chk_bump) begin
                    state_s    = ST_DONE;
                    hit_s      = 1'b1;
                    hit_idx_s  = idx_r;
                    movement_s = chk_movement;
                end else if (idx_r == LAST_IDX) begin
                    state_s    = ST_DONE;
                    hit_s      = 1'b0;
                    hit_idx_s  = '0;
                    movement_s = 10'd0;
                end else begin
                    idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, index, snapshot and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            snap_x_r   <= '0;
            snap_y_r   <= '0;
            hit_r      <= 1'b0;
            hit_idx_r  <= '0;
            movement_r <= 10'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            hit_r      <= hit_s;
            hit_idx_r  <= hit_idx_s;
            movement_r <= movement_s;
            busy_r     <= (state_s == ST_SCAN);
            done_r     <= (state_s == ST_DONE);
            if (snap_load_s) begin
                snap_x_r <= plat_x;
                snap_y_r <= plat_y;
            end else begin
                snap_x_r <= snap_x_r;
                snap_y_r <= snap_y_r;
            end
        end
    end

    // A tick that cannot be served is remembered until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (frame_tick && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // The checker is combinational, so the presented entry must track idx directly
    always_comb begin
        if ((state_r == ST_SCAN) && !rst) begin
            chk_block_x = snap_x_r[int'(idx_r)*10 +: 10];
            chk_block_y = snap_y_r[int'(idx_r)*10 +: 10];
        end else begin
            chk_block_x = 10'd0;
            chk_block_y = 10'd0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hit      = hit_r;
    assign hit_idx  = hit_idx_r;
    assign movement = movement_r;
    assign overrun  = overrun_r;

endmodule

// File: doc/bump_scan_ctrl.md
BUMP_SCAN_CTRL -- requirements
Module: bump_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 8: number of platforms scanned per frame (2..16).
REQ-002 SHALL have parameter IDX_W, default 3: width of the platform index, equal to clog2(NUM_BLOCKS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port frame_tick, input, 1 bit: one-cycle pulse that requests a scan.
REQ-006 SHALL have port fly, input, 1 bit: doodle is rising, so collision is disabled for this frame.
REQ-007 SHALL have port plat_x, input, NUM_BLOCKS*10 bits: packed platform x values, block k at bits [10k+9:10k].
REQ-008 SHALL have port plat_y, input, NUM_BLOCKS*10 bits: packed platform y values, same packing as plat_x.
REQ-009 SHALL have port chk_block_x, output, 10 bits: platform x presented to the shared combinational collision checker.
REQ-010 SHALL have port chk_block_y, output, 10 bits: platform y presented to the shared checker.
REQ-011 SHALL have port chk_bump, input, 1 bit: checker hit result for the presented platform, valid in the same cycle.
REQ-012 SHALL have port chk_movement, input, 10 bits: checker scroll amount for the presented platform.
REQ-013 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the result registers are updated.
REQ-015 SHALL have port hit, output, 1 bit: the last scan found a landing.
REQ-016 SHALL have port hit_idx, output, IDX_W bits: index of the platform that was hit.
REQ-017 SHALL have port movement, output, 10 bits: latched scroll amount from the last scan.
REQ-018 SHALL have port overrun, output, 1 bit: sticky flag, set when a frame_tick arrives while the block is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, SCAN and DONE, all registered.
REQ-020 In IDLE with frame_tick=1 and fly=0, SHALL at the clock edge snapshot plat_x and plat_y, set idx to 0 and go to SCAN.
REQ-021 In IDLE with frame_tick=1 and fly=1, SHALL go directly to DONE with a pending result of hit=0, movement=0 and hit_idx=0, without scanning.
REQ-022 In SCAN, SHALL drive chk_block_x and chk_block_y from the snapshot entry at idx; in all other states SHALL drive both to 0.
REQ-023 In SCAN with chk_bump=1 at the edge, SHALL capture hit=1, hit_idx=idx and movement=chk_movement, then go to DONE, so the lowest index wins and the scan terminates early.
REQ-024 In SCAN with chk_bump=0 and idx=NUM_BLOCKS-1, SHALL capture hit=0, hit_idx=0 and movement=0, then go to DONE.
REQ-025 In SCAN with chk_bump=0 and idx<NUM_BLOCKS-1, SHALL increment idx by 1; idx never wraps.
REQ-026 In DONE, SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 SHALL assert busy=1 exactly in SCAN.
REQ-028 SHALL hold hit, hit_idx and movement constant except at the edge that enters DONE.
REQ-029 SHALL assert done exactly min(i,NUM_BLOCKS-1)+2 cycles after the frame_tick cycle when the first hit is at index i, and NUM_BLOCKS+1 cycles after it when no platform hits.
REQ-030 SHALL assert done exactly 1 cycle after the frame_tick cycle when fly=1.
REQ-031 SHALL use only the snapshot during a scan, so changes on plat_x/plat_y after the start edge have no effect until the next scan.
REQ-032 SHALL ignore fly after the start edge.
REQ-033 SHALL ignore a frame_tick that arrives in SCAN or DONE, and SHALL set overrun=1 in that case.
REQ-034 SHALL clear overrun only on reset.
REQ-035 SHALL pass movement through the full 10-bit width unmodified, with no arithmetic applied.

Reset
REQ-036 With rst=1 at an edge, SHALL enter IDLE and clear to 0: idx, the snapshot, busy, done, hit, hit_idx, movement and overrun.
REQ-037 SHALL give rst priority over frame_tick in the same cycle.
REQ-038 SHALL abort a scan when rst arrives mid-scan: no done pulse and the result registers cleared.
REQ-039 SHALL drive chk_block_x and chk_block_y to 0 while in reset.

Verification
REQ-040 Hit at index 3 (NUM_BLOCKS=8): frame_tick with fly=0, checker returns bump=1 only when chk_block_y=300, with plat_y[3]=300 and movement 164 -> done 5 cycles after the tick, hit=1, hit_idx=3, movement=164, busy high for 4 cycles.
REQ-041 No hit: checker bump always 0 -> done 9 cycles after the tick, hit=0, hit_idx=0, movement=0, chk_block_y steps through plat_y[0..7] in order.
REQ-042 Multiple hits: indices 2 and 5 both hit -> hit_idx=2, and index 5 is never presented.
REQ-043 fly=1 at the tick -> done 1 cycle after the tick, hit=0, busy never asserted, chk_block_x/y stay 0.
REQ-044 Overrun and snapshot: second frame_tick 2 cycles after the first, and plat_y[4] changed mid-scan -> overrun=1 and stays 1, the second tick produces no scan, and the scan uses the old plat_y[4].
REQ-045 Reset mid-scan: rst=1 while idx=2 -> next cycle IDLE with busy=0, no done, all outputs 0; a subsequent tick scans normally.
